// File: rtl/rx_tlp_req_arbiter_pkg.sv
// Shared types for the rx TLP request arbiter: fsm states, qword width, request kinds.
package rx_tlp_req_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        DROP   = 2'd2,
        ACKLOW = 2'd3
    } arb_state_t;

    localparam int QW_CNT_W = 5;

    localparam logic KIND_TLP = 1'b0;
    localparam logic KIND_CHG = 1'b1;

endpackage

// File: rtl/rx_tlp_req_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or above ptr, wrapping.
module rx_tlp_req_arbiter_rr_pick #(
    parameter int NUM_PORTS = 2,
    parameter int PORT_W    = 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    ptr,
    output logic [PORT_W-1:0]    idx,
    output logic                 valid
);

    int cand;

    // Walk from farthest to nearest so the closest set port overwrites last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            cand = (int'(ptr) + i) % NUM_PORTS;
            if (req[cand]) begin
                idx   = PORT_W'(cand);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_tlp_req_arbiter.sv
// Round-robin sharing of one TLP send engine among NUM_PORTS requesters.
// Optional RX_TLP_ARB_STATS_EN adds per-port 32-bit grant counters (grant_count).
module rx_tlp_req_arbiter
    import rx_tlp_req_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int PORT_W    = 1
) (
    input  logic                            clk156,
    input  logic                            reset_n,
    input  logic [NUM_PORTS-1:0]            req_trigger_tlp,
    input  logic [NUM_PORTS-1:0]            req_change_huge_page,
    input  logic [NUM_PORTS-1:0]            req_send_last_tlp,
    input  logic [QW_CNT_W*NUM_PORTS-1:0]   req_qwords_to_send,
    output logic [NUM_PORTS-1:0]            req_trigger_tlp_ack,
    output logic [NUM_PORTS-1:0]            req_change_huge_page_ack,
    output logic                            eng_trigger_tlp,
    output logic                            eng_change_huge_page,
    output logic                            eng_send_last_tlp,
    output logic [QW_CNT_W-1:0]             eng_qwords_to_send,
    output logic [PORT_W-1:0]               eng_port_sel,
    input  logic                            eng_trigger_tlp_ack,
    input  logic                            eng_change_huge_page_ack
`ifdef RX_TLP_ARB_STATS_EN
    ,
    output logic [32*NUM_PORTS-1:0]         grant_count
`endif
);

    localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORTS - 1);
    localparam logic [NUM_PORTS-1:0] PORT0_OH = {{(NUM_PORTS-1){1'b0}}, 1'b1};

    logic tlp_ack_m, tlp_ack_s;
    logic chg_ack_m, chg_ack_s;

    always_ff @(posedge clk156 or negedge reset_n) begin
        if (!reset_n) begin
            tlp_ack_m <= 1'b0;
            tlp_ack_s <= 1'b0;
            chg_ack_m <= 1'b0;
            chg_ack_s <= 1'b0;
        end else begin
            tlp_ack_m <= eng_trigger_tlp_ack;
            tlp_ack_s <= tlp_ack_m;
            chg_ack_m <= eng_change_huge_page_ack;
            chg_ack_s <= chg_ack_m;
        end
    end

    arb_state_t state_q, state_n;
    logic [PORT_W-1:0]    sel_q, sel_n;
    logic [PORT_W-1:0]    rr_q, rr_n;
    logic                 kind_q, kind_n;
    logic                 sl_q, sl_n;
    logic [QW_CNT_W-1:0]  qw_q, qw_n;
    logic                 eng_trig_q, eng_trig_n;
    logic                 eng_chg_q, eng_chg_n;
    logic [NUM_PORTS-1:0] tlp_ack_q, tlp_ack_n;
    logic [NUM_PORTS-1:0] chg_ack_q, chg_ack_n;

    logic [NUM_PORTS-1:0] req_any;
    logic [PORT_W-1:0]    pick_idx;
    logic                 pick_vld;
    logic                 kind_ack_s;
    logic                 kind_req;
    logic [NUM_PORTS-1:0] sel_oh;

    assign req_any    = req_trigger_tlp | req_change_huge_page;
    assign kind_ack_s = kind_q ? chg_ack_s : tlp_ack_s;
    assign kind_req   = kind_q ? req_change_huge_page[sel_q]
                               : req_trigger_tlp[sel_q];
    assign sel_oh     = PORT0_OH << sel_q;

    rx_tlp_req_arbiter_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_rr_pick (
        .req   (req_any),
        .ptr   (rr_q),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    always_comb begin
        state_n    = state_q;
        sel_n      = sel_q;
        rr_n       = rr_q;
        kind_n     = kind_q;
        sl_n       = sl_q;
        qw_n       = qw_q;
        eng_trig_n = eng_trig_q;
        eng_chg_n  = eng_chg_q;
        tlp_ack_n  = tlp_ack_q;
        chg_ack_n  = chg_ack_q;
        unique case (state_q)
            IDLE: begin
                // A lingering engine ack from the last transaction blocks new grants.
                if (!tlp_ack_s && !chg_ack_s && pick_vld) begin
                    sel_n      = pick_idx;
                    kind_n     = req_change_huge_page[pick_idx] ? KIND_CHG : KIND_TLP;
                    sl_n       = req_send_last_tlp[pick_idx];
                    qw_n       = req_qwords_to_send[int'(pick_idx)*QW_CNT_W +: QW_CNT_W];
                    eng_chg_n  = req_change_huge_page[pick_idx];
                    eng_trig_n = !req_change_huge_page[pick_idx];
                    state_n    = REQ;
                end
            end
            REQ: begin
                if (kind_ack_s) begin
                    if (kind_q == KIND_CHG) chg_ack_n = sel_oh;
                    else                    tlp_ack_n = sel_oh;
                    state_n = DROP;
                end
            end
            DROP: begin
                if (!kind_req) begin
                    tlp_ack_n  = '0;
                    chg_ack_n  = '0;
                    eng_trig_n = 1'b0;
                    eng_chg_n  = 1'b0;
                    state_n    = ACKLOW;
                end
            end
            ACKLOW: begin
                if (!kind_ack_s) begin
                    rr_n    = (sel_q == LAST_PORT) ? '0 : sel_q + 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk156 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            rr_q       <= '0;
            kind_q     <= KIND_TLP;
            sl_q       <= 1'b0;
            qw_q       <= '0;
            eng_trig_q <= 1'b0;
            eng_chg_q  <= 1'b0;
            tlp_ack_q  <= '0;
            chg_ack_q  <= '0;
        end else begin
            state_q    <= state_n;
            sel_q      <= sel_n;
            rr_q       <= rr_n;
            kind_q     <= kind_n;
            sl_q       <= sl_n;
            qw_q       <= qw_n;
            eng_trig_q <= eng_trig_n;
            eng_chg_q  <= eng_chg_n;
            tlp_ack_q  <= tlp_ack_n;
            chg_ack_q  <= chg_ack_n;
        end
    end

    assign req_trigger_tlp_ack      = tlp_ack_q;
    assign req_change_huge_page_ack = chg_ack_q;
    assign eng_trigger_tlp          = eng_trig_q;
    assign eng_change_huge_page     = eng_chg_q;
    assign eng_send_last_tlp        = sl_q;
    assign eng_qwords_to_send       = qw_q;
    assign eng_port_sel             = sel_q;

`ifdef RX_TLP_ARB_STATS_EN
    logic grant_inc;

    assign grant_inc = (state_q == REQ) && kind_ack_s;

    always_ff @(posedge clk156 or negedge reset_n) begin
        if (!reset_n) begin
            grant_count <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (grant_inc && sel_q == PORT_W'(p))
                    grant_count[32*p +: 32] <= grant_count[32*p +: 32] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rx_tlp_req_arbiter.sv
// Directed table-driven bench for rx_tlp_req_arbiter with a hand-driven engine model.
module tb_rx_tlp_req_arbiter;

    localparam int N  = 2;
    localparam int PW = 1;

    logic          clk156 = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  req_trigger_tlp = '0;
    logic [N-1:0]  req_change_huge_page = '0;
    logic [N-1:0]  req_send_last_tlp = '0;
    logic [5*N-1:0] req_qwords_to_send = '0;
    logic [N-1:0]  req_trigger_tlp_ack;
    logic [N-1:0]  req_change_huge_page_ack;
    logic          eng_trigger_tlp;
    logic          eng_change_huge_page;
    logic          eng_send_last_tlp;
    logic [4:0]    eng_qwords_to_send;
    logic [PW-1:0] eng_port_sel;
    logic          eng_trigger_tlp_ack = 1'b0;
    logic          eng_change_huge_page_ack = 1'b0;
`ifdef RX_TLP_ARB_STATS_EN
    logic [32*N-1:0] grant_count;
`endif

    rx_tlp_req_arbiter #(.NUM_PORTS(N), .PORT_W(PW)) dut (
        .clk156                   (clk156),
        .reset_n                  (reset_n),
        .req_trigger_tlp          (req_trigger_tlp),
        .req_change_huge_page     (req_change_huge_page),
        .req_send_last_tlp        (req_send_last_tlp),
        .req_qwords_to_send       (req_qwords_to_send),
        .req_trigger_tlp_ack      (req_trigger_tlp_ack),
        .req_change_huge_page_ack (req_change_huge_page_ack),
        .eng_trigger_tlp          (eng_trigger_tlp),
        .eng_change_huge_page     (eng_change_huge_page),
        .eng_send_last_tlp        (eng_send_last_tlp),
        .eng_qwords_to_send       (eng_qwords_to_send),
        .eng_port_sel             (eng_port_sel),
        .eng_trigger_tlp_ack      (eng_trigger_tlp_ack),
        .eng_change_huge_page_ack (eng_change_huge_page_ack)
`ifdef RX_TLP_ARB_STATS_EN
        ,
        .grant_count              (grant_count)
`endif
    );

    always #3 clk156 = ~clk156;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] trig;
        logic [1:0] chg;
        logic [1:0] sl;
        logic [9:0] qw;
        int         sel_e;
        bit         chg_e;
        bit         sl_e;
        logic [4:0] qw_e;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {48'd0, req_trigger_tlp_ack, req_change_huge_page_ack,
                eng_trigger_tlp, eng_change_huge_page, eng_send_last_tlp,
                eng_qwords_to_send, eng_port_sel};
    endfunction

    task automatic wait_eng(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 12; i++) begin
            if (eng_trigger_tlp || eng_change_huge_page) begin
                ok = 1;
                break;
            end
            @(negedge clk156);
        end
        check(name, ok, 1);
    endtask

    task automatic ack_phase(input int sel, input bit is_chg, input bit clear_all);
        bit seen;
        logic [1:0] oh;
        oh = 2'b01 << sel;
        repeat (3) @(negedge clk156);
        if (is_chg) eng_change_huge_page_ack = 1'b1;
        else        eng_trigger_tlp_ack = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if ((req_trigger_tlp_ack | req_change_huge_page_ack) != 0) begin
                seen = 1;
                break;
            end
            @(negedge clk156);
        end
        check("port_ack_seen", seen, 1);
        check("tlp_ack_vec", req_trigger_tlp_ack, is_chg ? 2'b00 : oh);
        check("chg_ack_vec", req_change_huge_page_ack, is_chg ? oh : 2'b00);
        if (clear_all) begin
            req_trigger_tlp      = '0;
            req_change_huge_page = '0;
            req_send_last_tlp    = '0;
        end else if (is_chg) begin
            req_change_huge_page[sel] = 1'b0;
        end else begin
            req_trigger_tlp[sel] = 1'b0;
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk156);
            if (!eng_trigger_tlp && !eng_change_huge_page) begin
                seen = 1;
                break;
            end
        end
        check("eng_req_drop", seen, 1);
        check("port_acks_low", {req_trigger_tlp_ack, req_change_huge_page_ack}, 0);
    endtask

    task automatic serve(input int sel, input bit is_chg, input bit clear_all);
        ack_phase(sel, is_chg, clear_all);
        eng_trigger_tlp_ack      = 1'b0;
        eng_change_huge_page_ack = 1'b0;
        repeat (5) @(negedge clk156);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad;
        tbl[0] = '{2'b01, 2'b00, 2'b00, {5'd0, 5'd16}, 0, 0, 0, 5'd16};
        tbl[1] = '{2'b00, 2'b10, 2'b10, {5'd5, 5'd3},  1, 1, 1, 5'd5};
        tbl[2] = '{2'b11, 2'b00, 2'b00, {5'd9, 5'd7},  0, 0, 0, 5'd7};
        tbl[3] = '{2'b11, 2'b00, 2'b11, {5'd9, 5'd7},  1, 0, 1, 5'd9};
        tbl[4] = '{2'b10, 2'b00, 2'b00, {5'd31, 5'd1}, 1, 0, 0, 5'd31};
        tbl[5] = '{2'b01, 2'b10, 2'b00, {5'd2, 5'd4},  0, 0, 0, 5'd4};
        tbl[6] = '{2'b00, 2'b01, 2'b01, {5'd8, 5'd0},  0, 1, 1, 5'd0};

        repeat (3) @(negedge clk156);
        check("reset_outputs", all_outs(), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk156);
        check("idle_outputs", all_outs(), 0);

        for (int v = 0; v < 7; v++) begin
            req_qwords_to_send   = tbl[v].qw;
            req_send_last_tlp    = tbl[v].sl;
            req_trigger_tlp      = tbl[v].trig;
            req_change_huge_page = tbl[v].chg;
            @(negedge clk156);
            wait_eng("tbl_grant");
            check("tbl_sel", eng_port_sel, tbl[v].sel_e);
            check("tbl_eng_chg", eng_change_huge_page, tbl[v].chg_e);
            check("tbl_eng_trig", eng_trigger_tlp, !tbl[v].chg_e);
            check("tbl_send_last", eng_send_last_tlp, tbl[v].sl_e);
            check("tbl_qwords", eng_qwords_to_send, tbl[v].qw_e);
            serve(tbl[v].sel_e, tbl[v].chg_e, 1);
        end

        req_qwords_to_send   = {5'd0, 5'd12};
        req_trigger_tlp      = 2'b01;
        req_change_huge_page = 2'b01;
        @(negedge clk156);
        wait_eng("both_grant1");
        check("both_first_chg", {eng_change_huge_page, eng_trigger_tlp}, 2'b10);
        check("both_first_sel", eng_port_sel, 0);
        serve(0, 1, 0);
        wait_eng("both_grant2");
        check("both_second_trig", {eng_change_huge_page, eng_trigger_tlp}, 2'b01);
        check("both_second_sel", eng_port_sel, 0);
        serve(0, 0, 1);

        req_trigger_tlp = 2'b10;
        @(negedge clk156);
        wait_eng("held_grant");
        check("held_sel", eng_port_sel, 1);
        ack_phase(1, 0, 0);
        req_trigger_tlp = 2'b01;
        bad = 0;
        repeat (20) begin
            @(negedge clk156);
            if (eng_trigger_tlp || eng_change_huge_page) bad = 1;
        end
        check("held_no_grant", bad, 0);
        eng_trigger_tlp_ack = 1'b0;
        wait_eng("held_after_grant");
        check("held_after_sel", eng_port_sel, 0);
        serve(0, 0, 1);

        req_trigger_tlp = 2'b10;
        req_qwords_to_send = {5'd21, 5'd3};
        @(negedge clk156);
        wait_eng("rst_grant");
        check("rst_pre_sel", eng_port_sel, 1);
        #1 reset_n = 1'b0;
        #1 check("rst_async_outputs", all_outs(), 0);
        req_trigger_tlp = 2'b11;
        @(negedge clk156);
        @(negedge clk156);
        reset_n = 1'b1;
        wait_eng("rst_regrant");
        check("rst_regrant_sel", eng_port_sel, 0);
        serve(0, 0, 1);

        @(negedge clk156);
        reset_n = 1'b0;
        @(negedge clk156);
        reset_n = 1'b1;
        req_qwords_to_send = {5'd2, 5'd1};
        req_trigger_tlp    = 2'b11;
        for (int i = 0; i < 6; i++) begin
            wait_eng("alt_grant");
            check("alt_sel", eng_port_sel, i % 2);
            check("alt_qwords", eng_qwords_to_send, (i % 2) ? 2 : 1);
            ack_phase(i % 2, 0, 0);
            eng_trigger_tlp_ack = 1'b0;
            req_trigger_tlp[i % 2] = 1'b1;
            repeat (5) @(negedge clk156);
        end
`ifdef RX_TLP_ARB_STATS_EN
        check("stats_port0", grant_count[31:0], 3);
        check("stats_port1", grant_count[63:32], 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
